// File: rtl/fifo_rv.sv
// First-word-fall-through FIFO with valid/ready on both sides, threshold flags,
// synchronous flush and a peak-occupancy monitor. Optional bypass: FIFO_RV_BYPASS_EN.
module fifo_rv #(
  parameter int PTR_W    = 4,
  parameter int DATA_W   = 8,
  parameter int AF_LEVEL = (2**PTR_W) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PTR_W:0]    level,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [PTR_W:0]    max_level
);

  localparam int SIZE = 2**PTR_W;
  localparam logic [PTR_W:0] SIZE_L = (PTR_W+1)'(SIZE);
  localparam logic [PTR_W:0] AF_L   = (PTR_W+1)'(AF_LEVEL);
  localparam logic [PTR_W:0] AE_L   = (PTR_W+1)'(AE_LEVEL);

  // Handshake: a word moves on a side only in a cycle where valid && ready are
  // both high at the rising edge; flush forces both readies/valids low.
  logic [DATA_W-1:0] mem [SIZE];
  logic [PTR_W:0]    wrptr;
  logic [PTR_W:0]    rdptr;
  logic [PTR_W:0]    max_q;
  logic [PTR_W:0]    level_w;
  logic [PTR_W:0]    next_level;
  logic              full;
  logic              empty;
  logic              fifo_valid;
  logic              byp_pass;
  logic              push;
  logic              pop;

  assign level_w    = wrptr - rdptr;
  assign full       = (level_w == SIZE_L);
  assign empty      = (level_w == '0);
  assign in_ready   = !full && !flush;
  assign fifo_valid = !empty && !flush;

`ifdef FIFO_RV_BYPASS_EN
  // An empty FIFO presents the producer's word directly; if taken, it is never stored.
  assign byp_pass  = empty && !flush && in_valid && out_ready;
  assign out_valid = (empty && !flush) ? in_valid : fifo_valid;
  assign out_data  = empty ? in_data : mem[rdptr[PTR_W-1:0]];
`else
  assign byp_pass  = 1'b0;
  assign out_valid = fifo_valid;
  assign out_data  = mem[rdptr[PTR_W-1:0]];
`endif

  assign push = in_valid && in_ready && !byp_pass;
  assign pop  = fifo_valid && out_ready;

  always_comb begin
    next_level = level_w;
    case ({push, pop})
      2'b10:   next_level = level_w + 1'b1;
      2'b01:   next_level = level_w - 1'b1;
      default: next_level = level_w;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrptr <= '0;
      rdptr <= '0;
      max_q <= '0;
    end else if (flush) begin
      wrptr <= '0;
      rdptr <= '0;
      max_q <= '0;
    end else begin
      if (push) wrptr <= wrptr + 1'b1;
      if (pop)  rdptr <= rdptr + 1'b1;
      if (next_level > max_q) max_q <= next_level;
    end
  end

  // Storage is deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wrptr[PTR_W-1:0]] <= in_data;
  end

  assign level        = level_w;
  assign almost_full  = (level_w >= AF_L);
  assign almost_empty = (level_w <= AE_L);
  assign max_level    = max_q;

endmodule

// File: tb/tb_fifo_rv.sv
// Directed + randomized bench for fifo_rv against a queue-based reference model.
module tb_fifo_rv;

  localparam int PTR_W  = 4;
  localparam int DATA_W = 8;
  localparam int SIZE   = 16;
  localparam int AF     = 14;
  localparam int AE     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [PTR_W:0]    level;
  logic              almost_full;
  logic              almost_empty;
  logic [PTR_W:0]    max_level;

  logic [DATA_W-1:0] exp_q[$];
  int                exp_max = 0;
  int                n_checks = 0;
  int                n_fail = 0;

  fifo_rv #(.PTR_W(PTR_W), .DATA_W(DATA_W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
    .max_level(max_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    int sz;
    sz = exp_q.size();
    chk("level", 32'(level), 32'(sz));
    chk("almost_full", 32'(almost_full), 32'(sz >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    chk("max_level", 32'(max_level), 32'(exp_max));
  endtask

  // One clock cycle: drive after the falling edge, check before the rising edge,
  // then advance the model by what the specification says the edge does.
  task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
    int   sz;
    logic byp;
    logic e_rdy;
    logic e_ov;
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    sz  = exp_q.size();
    byp = 1'b0;
`ifdef FIFO_RV_BYPASS_EN
    byp = (sz == 0) && !fl;
`endif
    e_rdy = (sz < SIZE) && !fl;
    e_ov  = byp ? iv : ((sz != 0) && !fl);
    check_status();
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    if (e_ov) chk("out_data", 32'(out_data), 32'(byp ? d : exp_q[0]));
    if (fl) begin
      exp_q.delete();
      exp_max = 0;
    end else if (!(byp && iv && ordy)) begin
      if (e_ov && ordy) void'(exp_q.pop_front());
      if (iv && e_rdy) exp_q.push_back(d);
      if (exp_q.size() > exp_max) exp_max = exp_q.size();
    end
    @(posedge clk);
  endtask

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    #1;
    check_status();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Fill to full, then an extra word that must be refused
    for (int i = 0; i < SIZE; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("full_max", 32'(max_level), 32'd16);
    chk("full_level", 32'(level), 32'd16);

    // Drain in order
    for (int i = 0; i < SIZE; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_max", 32'(max_level), 32'd16);

    // Steady state at level 5 across pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h25 + i), 1'b1, 1'b0);
    chk("steady_level", 32'(level), 32'd5);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Full-depth fill/drain straddling the write-pointer wrap
    for (int i = 0; i < SIZE; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < SIZE; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush at level 9 with both handshakes requested
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_max", 32'(max_level), 32'd0);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Empty FIFO, producer and consumer both ready
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 40) == 0));
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_max = 0;
    check_status();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
